// File: rtl/fsm_table_ctrl.sv
// Table-driven 8-state FSM sequencer: loads a 32-entry next-state/output table over a
// valid/ready port, then replays it free-running or one transition at a time.
module fsm_table_ctrl #(
    parameter int unsigned SW    = 3,
    parameter int unsigned IW    = 2,
    parameter int unsigned OW    = 3,
    parameter int unsigned DEPTH = 2 ** (SW + IW),
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [OW+SW-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             run_en,
    input  logic             step,
    input  logic [IW-1:0]    a,
    output logic [OW-1:0]    saida,
    output logic [SW-1:0]    state_q,
    output logic [1:0]       mode,
    output logic             loaded,
    output logic [CW-1:0]    trans_cnt
);

    localparam int unsigned AW = SW + IW;
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StReady = 2'd2,
        StRun   = 2'd3
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    state_d;
    logic [OW-1:0]    saida_d;
    logic             loaded_d;
    logic [CW-1:0]    cnt_d;
    logic             advance;
    logic [OW+SW-1:0] entry;

    // Table memory is deliberately left out of reset.
    logic [OW+SW-1:0] tbl [DEPTH];

    always_ff @(posedge clk) begin
        if (mode_q == StLoad && cfg_valid) begin
            tbl[idx_q] <= cfg_data;
        end
    end

    assign entry     = tbl[{state_q, a}];
    assign cfg_ready = (mode_q == StLoad);
    assign mode      = mode_q;

    always_comb begin
        mode_d   = mode_q;
        idx_d    = idx_q;
        state_d  = state_q;
        saida_d  = saida;
        loaded_d = loaded;
        cnt_d    = trans_cnt;
        advance  = 1'b0;

        case (mode_q)
            StIdle: begin
                if (cfg_start) begin
                    mode_d   = StLoad;
                    idx_d    = '0;
                    loaded_d = 1'b0;
                end
            end
            StLoad: begin
                if (cfg_valid) begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == LastIdx) begin
                        mode_d   = StReady;
                        loaded_d = 1'b1;
                        state_d  = '0;
                        saida_d  = '0;
                        cnt_d    = '0;
                    end
                end
            end
            StReady: begin
                if (cfg_start) begin
                    mode_d   = StLoad;
                    idx_d    = '0;
                    loaded_d = 1'b0;
                end else if (run_en) begin
                    mode_d = StRun;
                end else if (step) begin
                    advance = 1'b1;
                end
            end
            StRun: begin
                if (run_en) begin
                    advance = 1'b1;
                end else begin
                    mode_d = StReady;
                end
            end
            default: mode_d = StIdle;
        endcase

        if (advance) begin
            state_d = entry[SW-1:0];
            saida_d = entry[OW+SW-1:SW];
            cnt_d   = trans_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= StIdle;
            idx_q     <= '0;
            state_q   <= '0;
            saida     <= '0;
            loaded    <= 1'b0;
            trans_cnt <= '0;
        end else begin
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            saida     <= saida_d;
            loaded    <= loaded_d;
            trans_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fsm_table_ctrl.sv
// Self-checking bench for fsm_table_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the controller.
module tb_fsm_table_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic        cfg_valid;
    logic [5:0]  cfg_data;
    logic        cfg_ready;
    logic        run_en;
    logic        step;
    logic [1:0]  a;
    logic [2:0]  saida;
    logic [2:0]  state_q;
    logic [1:0]  mode;
    logic        loaded;
    logic [15:0] trans_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 IDLE, 1 LOAD, 2 READY, 3 RUN
    int m_mode, m_idx, m_state, m_out, m_loaded, m_cnt;
    int m_tab[32];
    int ld_tab[32];

    fsm_table_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .run_en    (run_en),
        .step      (step),
        .a         (a),
        .saida     (saida),
        .state_q   (state_q),
        .mode      (mode),
        .loaded    (loaded),
        .trans_cnt (trans_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_state = 0; m_out = 0; m_loaded = 0; m_cnt = 0;
    endtask

    task automatic model_advance();
        int e;
        e       = m_tab[m_state * 4 + int'(a)];
        m_out   = e / 8;
        m_state = e % 8;
        m_cnt   = (m_cnt + 1) % 65536;
    endtask

    task automatic model_edge();
        case (m_mode)
            0: if (cfg_start) begin m_mode = 1; m_idx = 0; m_loaded = 0; end
            1: if (cfg_valid) begin
                m_tab[m_idx] = int'(cfg_data);
                if (m_idx == 31) begin
                    m_mode = 2; m_loaded = 1; m_state = 0; m_out = 0; m_cnt = 0;
                end
                m_idx = (m_idx + 1) % 32;
            end
            2: if (cfg_start) begin m_mode = 1; m_idx = 0; m_loaded = 0; end
               else if (run_en) m_mode = 3;
               else if (step) model_advance();
            default: if (run_en) model_advance(); else m_mode = 2;
        endcase
    endtask

    task automatic check_all();
        chk("mode", 32'(mode), m_mode);
        chk("state_q", 32'(state_q), m_state);
        chk("saida", 32'(saida), m_out);
        chk("loaded", 32'(loaded), m_loaded);
        chk("trans_cnt", 32'(trans_cnt), m_cnt);
        chk("cfg_ready", 32'(cfg_ready), 32'(m_mode == 1));
    endtask

    // One rising edge: model follows the same sampled inputs, outputs checked 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        cfg_start = 0; cfg_valid = 0; cfg_data = '0; run_en = 0; step = 0;
    endtask

    // gap: 0 back-to-back, 1 valid every other cycle, 2 random gaps
    task automatic do_load(input int gap);
        int i = 0;
        int k = 0;
        idle_inputs();
        if (m_mode == 3) cycle();
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        while (i < 32) begin
            case (gap)
                0:       cfg_valid = 1;
                1:       cfg_valid = (k % 2 == 0);
                default: cfg_valid = ($urandom_range(0, 3) != 0);
            endcase
            cfg_data = 6'(ld_tab[i]);
            cycle();
            if (cfg_valid) i++;
            if (i == 31 && cfg_valid) chk("load_not_done", 32'(mode), 1);
            k++;
        end
        cfg_valid = 0;
        chk("load_ready", 32'(mode), 2);
        chk("load_loaded", 32'(loaded), 1);
    endtask

    task automatic pulse_step();
        step = 1;
        cycle();
        step = 0;
        cycle();
    endtask

    task automatic inc_table();
        for (int s = 0; s < 8; s++)
            for (int j = 0; j < 4; j++)
                ld_tab[s * 4 + j] = s * 8 + (s + 1) % 8;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_tab[i] = 0;
        idle_inputs();
        a = 0;
        reset = 0;
        #2;
        model_reset();
        check_all();
        #6 reset = 1;

        // Incrementing table, back-to-back, then free-run 10 transitions
        inc_table();
        do_load(0);
        run_en = 1;
        cycle();
        chk("run_enter_state", 32'(state_q), 0);
        for (int k = 0; k < 10; k++) begin
            a = 2'($urandom_range(0, 3));
            cycle();
            chk("run_saida_seq", 32'(saida), k % 8);
        end
        chk("run_end_state", 32'(state_q), 2);
        chk("run_end_cnt", 32'(trans_cnt), 10);
        run_en = 0;
        cycle();

        // Single steps
        do_load(0);
        for (int k = 0; k < 3; k++) begin
            a = 2'($urandom_range(0, 3));
            pulse_step();
        end
        chk("step_state", 32'(state_q), 3);
        chk("step_saida", 32'(saida), 2);
        chk("step_cnt", 32'(trans_cnt), 3);
        chk("step_mode", 32'(mode), 2);

        // run_en + step together, cfg_start ignored in RUN, clean drop back
        run_en = 1; step = 1;
        cycle();
        chk("runstep_mode", 32'(mode), 3);
        chk("runstep_state", 32'(state_q), 3);
        step = 0; cfg_start = 1;
        cycle();
        chk("run_ignores_start", 32'(mode), 3);
        chk("run_adv_state", 32'(state_q), 4);
        cfg_start = 0; run_en = 0;
        cycle();
        chk("run_drop_mode", 32'(mode), 2);
        chk("run_drop_state", 32'(state_q), 4);
        chk("run_drop_cnt", 32'(trans_cnt), 4);

        // Gapped load of a random table, read back by stepping
        for (int i = 0; i < 32; i++) ld_tab[i] = int'($urandom_range(0, 63));
        do_load(1);
        for (int k = 0; k < 48; k++) begin
            a = 2'($urandom_range(0, 3));
            pulse_step();
        end

        // Team sequence table
        for (int i = 0; i < 32; i++) ld_tab[i] = int'($urandom_range(0, 63));
        ld_tab[0] = 'h01; ld_tab[3] = 'h05; ld_tab[7] = 'h0D; ld_tab[12] = 'h18;
        ld_tab[23] = 'h2E; ld_tab[27] = 'h33; ld_tab[31] = 'h1D;
        do_load(2);
        a = 3;
        pulse_step();
        chk("team_s1", 32'(state_q), 5); chk("team_o1", 32'(saida), 0);
        pulse_step();
        chk("team_s2", 32'(state_q), 6); chk("team_o2", 32'(saida), 5);
        pulse_step();
        chk("team_s3", 32'(state_q), 3); chk("team_o3", 32'(saida), 6);
        a = 0;
        pulse_step();
        chk("team_s4", 32'(state_q), 0); chk("team_o4", 32'(saida), 3);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            cfg_start = ($urandom_range(0, 63) == 0);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) run_en = ~run_en;
            step      = ($urandom_range(0, 2) == 0);
            a         = 2'($urandom_range(0, 3));
            cycle();
        end
        idle_inputs();
        cycle();

        // Async reset in the middle of a load
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cfg_valid = 1;
        for (int k = 0; k < 10; k++) begin
            cfg_data = 6'($urandom_range(0, 63));
            cycle();
        end
        cfg_valid = 0;
        reset = 0;
        #1;
        model_reset();
        chk("rst_mode", 32'(mode), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_loaded", 32'(loaded), 0);
        check_all();
        #1 reset = 1;
        run_en = 1; step = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("idle_ignores_run", 32'(mode), 0);
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
